// File: rtl/tt_um_accelshark_psg_i2s_rx_pkg.sv
// Shared I2S link constants: default word/counter widths and receiver state encodings.
// The transmitter uses the same default WIDTH.
package tt_um_accelshark_psg_i2s_rx_pkg;

    localparam int I2S_WIDTH = 16;
    localparam int I2S_CNT_W = 6;

    localparam logic [1:0] ST_UNSYNCED    = 2'd0;
    localparam logic [1:0] ST_WAIT_R_SKIP = 2'd1;
    localparam logic [1:0] ST_WAIT_L      = 2'd2;
    localparam logic [1:0] ST_WAIT_R      = 2'd3;

endpackage

// File: rtl/tt_um_accelshark_psg_sync.sv
// Two-flop synchroniser for a single asynchronous input bit.
module tt_um_accelshark_psg_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_um_accelshark_psg_i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCK/SDATA on clk, deserialises left/right slots
// and presents a stereo pair with a one-cycle valid strobe.
module tt_um_accelshark_psg_i2s_rx
    import tt_um_accelshark_psg_i2s_rx_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH,
    parameter int CNT_W = I2S_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sclk,
    input  logic             lrck,
    input  logic             sdata,
    output logic [WIDTH-1:0] rx_l,
    output logic [WIDTH-1:0] rx_r,
    output logic             rx_valid,
    output logic             frame_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sclk_s, lrck_s, sdata_s, sclk_d, sclk_rise;

    tt_um_accelshark_psg_sync u_sync_sclk  (.clk(clk), .rst_n(rst_n), .d(sclk),  .q(sclk_s));
    tt_um_accelshark_psg_sync u_sync_lrck  (.clk(clk), .rst_n(rst_n), .d(lrck),  .q(lrck_s));
    tt_um_accelshark_psg_sync u_sync_sdata (.clk(clk), .rst_n(rst_n), .d(sdata), .q(sdata_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sclk_d <= 1'b0;
        else        sclk_d <= sclk_s;
    end

    assign sclk_rise = sclk_s & ~sclk_d;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx, word;
    logic [WIDTH-1:0] l_stage, l_stage_nx, rx_l_nx, rx_r_nx;
    logic [CNT_W-1:0] bitcnt, bitcnt_nx, cnt_inc;
    logic             lrck_prev, lrck_prev_nx, lrck_seen, lrck_seen_nx;
    logic             valid_nx, err_nx, slot_end, word_ok;

    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        l_stage_nx   = l_stage;
        rx_l_nx      = rx_l;
        rx_r_nx      = rx_r;
        bitcnt_nx    = bitcnt;
        lrck_prev_nx = lrck_prev;
        lrck_seen_nx = lrck_seen;
        valid_nx     = 1'b0;
        err_nx       = 1'b0;

        cnt_inc  = (bitcnt == CNT_MAX) ? bitcnt : bitcnt + 1'b1;
        // Bits past WIDTH are dropped so a long slot keeps its MSBs.
        word     = (int'(bitcnt) < WIDTH) ? {shreg[WIDTH-2:0], sdata_s} : shreg;
        word_ok  = int'(cnt_inc) >= WIDTH;
        // lrck_seen keeps the reset value of lrck_prev from faking a transition.
        slot_end = sclk_rise && lrck_seen && (lrck_s != lrck_prev);

        if (!ena) begin
            state_nx     = ST_UNSYNCED;
            bitcnt_nx    = '0;
            lrck_seen_nx = 1'b0;
        end else if (sclk_rise) begin
            lrck_prev_nx = lrck_s;
            lrck_seen_nx = 1'b1;
            shreg_nx     = word;
            bitcnt_nx    = cnt_inc;
            if (slot_end) begin
                shreg_nx  = '0;
                bitcnt_nx = '0;
                case (state)
                    ST_UNSYNCED:    state_nx = lrck_s ? ST_WAIT_R_SKIP : ST_WAIT_L;
                    ST_WAIT_R_SKIP: state_nx = ST_WAIT_L;
                    ST_WAIT_L: begin
                        // After an error the right slot also ends here; only a left slot is collected.
                        if (!lrck_prev) begin
                            if (word_ok) begin
                                l_stage_nx = word;
                                state_nx   = ST_WAIT_R;
                            end else begin
                                err_nx = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_nx = ST_WAIT_L;
                        if (word_ok) begin
                            rx_l_nx  = l_stage;
                            rx_r_nx  = word;
                            valid_nx = 1'b1;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_UNSYNCED;
            shreg     <= '0;
            l_stage   <= '0;
            rx_l      <= '0;
            rx_r      <= '0;
            bitcnt    <= '0;
            lrck_prev <= 1'b0;
            lrck_seen <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            l_stage   <= l_stage_nx;
            rx_l      <= rx_l_nx;
            rx_r      <= rx_r_nx;
            bitcnt    <= bitcnt_nx;
            lrck_prev <= lrck_prev_nx;
            lrck_seen <= lrck_seen_nx;
            rx_valid  <= valid_nx;
            frame_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_tt_um_accelshark_psg_i2s_rx.sv
// Directed bench for the I2S receiver: clk = 8x SCLK, transmitter drives LRCK/SDATA on SCLK fall.
module tb_tt_um_accelshark_psg_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        sclk = 1'b0;
    logic        lrck = 1'b0;
    logic        sdata = 1'b0;
    logic [15:0] rx_l, rx_r;
    logic        rx_valid, frame_err;

    int checks = 0;
    int errors = 0;
    int vcnt = 0, ecnt = 0, both = 0, vedge = 0;
    logic vprev = 1'b0;

    tt_um_accelshark_psg_i2s_rx dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sclk(sclk), .lrck(lrck), .sdata(sdata),
        .rx_l(rx_l), .rx_r(rx_r), .rx_valid(rx_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) vcnt++;
        if (rx_valid && !vprev) vedge++;
        if (frame_err) ecnt++;
        if (rx_valid && frame_err) both++;
        vprev = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // word is MSB-aligned: bit i of the slot is word[31-i], zeros beyond 32 bits.
    // With flip set, lrck moves to the other channel on the slot's last bit.
    task automatic send_slot(input logic ch, input logic [31:0] word, input int n, input logic flip);
        for (int i = 0; i < n; i++) begin
            sdata = (i < 32) ? word[31-i] : 1'b0;
            lrck  = (flip && i == n-1) ? ~ch : ch;
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nl, input int nr);
        send_slot(1'b0, l, nl, 1'b1);
        send_slot(1'b1, r, nr, 1'b1);
        #100;
    endtask

    initial begin
        #100;
        chk("reset_rx_l", rx_l, 0);
        chk("reset_rx_r", rx_r, 0);
        chk("reset_valid", rx_valid, 0);
        chk("reset_err", frame_err, 0);
        rst_n = 1'b1;
        #20;

        // First frame only synchronises.
        send_frame(32'h1111_0000, 32'h2222_0000, 16, 16);
        chk("sync_no_valid", vcnt, 0);
        send_frame(32'h1234_0000, 32'hABCD_0000, 16, 16);
        chk("f16_vcnt", vcnt, 1);
        chk("f16_l", rx_l, 16'h1234);
        chk("f16_r", rx_r, 16'hABCD);
        send_frame(32'h5555_0000, 32'hAAAA_0000, 16, 16);
        chk("f16b_vcnt", vcnt, 2);
        chk("f16b_l", rx_l, 16'h5555);
        chk("f16b_r", rx_r, 16'hAAAA);

        // 32-bit slots keep the 16 MSBs.
        send_frame(32'h8001_FFFF, 32'h7FFE_0000, 32, 32);
        chk("f32_vcnt", vcnt, 3);
        chk("f32_l", rx_l, 16'h8001);
        chk("f32_r", rx_r, 16'h7FFE);
        chk("f32_noerr", ecnt, 0);

        // Short left slot.
        send_frame(32'hDEAD_0000, 32'hBEEF_0000, 15, 16);
        chk("shortl_err", ecnt, 1);
        chk("shortl_novalid", vcnt, 3);
        chk("shortl_hold_l", rx_l, 16'h8001);
        chk("shortl_hold_r", rx_r, 16'h7FFE);
        send_frame(32'h0F0F_0000, 32'hF0F0_0000, 16, 16);
        chk("recover_vcnt", vcnt, 4);
        chk("recover_l", rx_l, 16'h0F0F);
        chk("recover_r", rx_r, 16'hF0F0);

        // Short right slot.
        send_frame(32'h1357_0000, 32'h2468_0000, 16, 10);
        chk("shortr_err", ecnt, 2);
        chk("shortr_novalid", vcnt, 4);
        chk("shortr_hold_l", rx_l, 16'h0F0F);
        send_frame(32'h3C3C_0000, 32'hC3C3_0000, 16, 16);
        chk("recover2_vcnt", vcnt, 5);
        chk("recover2_l", rx_l, 16'h3C3C);

        // 70-bit slots: bit counter saturates, word still good.
        send_frame(32'hCAFE_BABE, 32'h1234_5678, 70, 70);
        chk("sat_vcnt", vcnt, 6);
        chk("sat_l", rx_l, 16'hCAFE);
        chk("sat_r", rx_r, 16'h1234);
        chk("sat_noerr", ecnt, 2);

        // Reset in the middle of a right slot.
        send_slot(1'b0, 32'h5A5A_0000, 16, 1'b1);
        send_slot(1'b1, 32'hA5A5_0000, 8, 1'b0);
        rst_n = 1'b0;
        #20;
        chk("midrst_l", rx_l, 0);
        chk("midrst_r", rx_r, 0);
        rst_n = 1'b1;
        #20;
        send_slot(1'b1, 32'h0000_0000, 8, 1'b1);
        #100;
        chk("midrst_partial_novalid", vcnt, 6);
        send_frame(32'h4242_0000, 32'h2424_0000, 16, 16);
        chk("midrst_vcnt", vcnt, 7);
        chk("midrst_new_l", rx_l, 16'h4242);
        chk("midrst_new_r", rx_r, 16'h2424);

        // ena low for three frames, one of them malformed.
        ena = 1'b0;
        send_frame(32'h9999_0000, 32'h9999_0000, 16, 16);
        send_frame(32'h9999_0000, 32'h9999_0000, 10, 16);
        send_frame(32'h9999_0000, 32'h9999_0000, 16, 16);
        chk("ena0_novalid", vcnt, 7);
        chk("ena0_noerr", ecnt, 2);
        chk("ena0_hold_l", rx_l, 16'h4242);
        ena = 1'b1;
        send_frame(32'h7777_0000, 32'h8888_0000, 16, 16);
        chk("ena1_sync_novalid", vcnt, 7);
        send_frame(32'h6161_0000, 32'h1616_0000, 16, 16);
        chk("ena1_vcnt", vcnt, 8);
        chk("ena1_l", rx_l, 16'h6161);
        chk("ena1_r", rx_r, 16'h1616);

        chk("no_overlap", both, 0);
        chk("valid_one_cycle", vcnt, vedge);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
